// File: rtl/pipo_pkg.sv
// Shared defaults and word type for pipo_reg users.
package pipo_pkg;

    localparam int PIPO_DEF_WIDTH  = 4;
    localparam int PIPO_DEF_STAGES = 1;

    typedef logic [PIPO_DEF_WIDTH-1:0] pipo_word_t;

    // All-zero word at the default width, the default reset value.
    function automatic pipo_word_t pipo_zero_word();
        return {PIPO_DEF_WIDTH{1'b0}};
    endfunction

endpackage

// File: rtl/pipo_stage.sv
// One WIDTH-bit register with synchronous active-high reset to RESET_VAL.
module pipo_stage
    import pipo_pkg::*;
#(
    parameter int                 WIDTH     = PIPO_DEF_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Stage register: reset wins over incoming data at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipo_reg.sv
// Parallel-in/parallel-out register chain of STAGES pipo_stage instances.
// Optional simulation checks are compiled in when PIPO_ASSERT_EN is defined.
`ifdef PIPO_ASSERT_EN
module pipo_reg_chk #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 1
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] q
);

    if (WIDTH < 1) begin : g_bad_width
        $error("pipo_reg: WIDTH must be >= 1");
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("pipo_reg: STAGES must be >= 1");
    end

    logic [WIDTH-1:0] d_hist_q [STAGES];
    int unsigned      run_q;

    // run_q counts non-reset edges since the last reset edge (saturating).
    always_ff @(posedge clk) begin
        d_hist_q[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
            d_hist_q[i] <= d_hist_q[i-1];
        end
        if (rst) begin
            run_q <= 32'd0;
        end else if (run_q < 32'(STAGES)) begin
            run_q <= run_q + 32'd1;
        end else begin
            run_q <= run_q;
        end
    end

    // q reflects the word captured STAGES edges ago when no reset fell in that window.
    always_ff @(posedge clk) begin
        if (run_q >= 32'(STAGES)) begin
            if (!$isunknown(d_hist_q[STAGES-1])) begin
                assert (!$isunknown(q)) else $error("pipo_reg: q unknown");
            end else begin
            end
            assert (q === d_hist_q[STAGES-1]) else $error("pipo_reg: latency check");
        end else begin
        end
    end

endmodule
`endif

module pipo_reg
    import pipo_pkg::*;
#(
    parameter int               WIDTH     = PIPO_DEF_WIDTH,
    parameter int               STAGES    = PIPO_DEF_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // chain_s[k] feeds stage k; chain_s[STAGES] is the last stage output.
    logic [WIDTH-1:0] chain_s [STAGES+1];

    assign chain_s[0] = d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipo_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (chain_s[k]),
            .q   (chain_s[k+1])
        );
    end

    assign q = chain_s[STAGES];

`ifdef PIPO_ASSERT_EN
    pipo_reg_chk #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_chk (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (q)
    );
`endif

endmodule

// File: tb/tb_pipo_reg.sv
// Scoreboard bench for pipo_reg: three configurations, directed vectors.
module tb_pipo_reg;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    logic [3:0] d_a = 4'd0, d_c = 4'd0;
    logic [7:0] d_b = 8'd0;
    logic [3:0] q_a, q_c;
    logic [7:0] q_b;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipo_reg u_a (.clk(clk), .rst(rst_a), .d(d_a), .q(q_a));

    pipo_reg #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'h00)) u_b (
        .clk(clk), .rst(rst_b), .d(d_b), .q(q_b));

    pipo_reg #(.WIDTH(4), .STAGES(1), .RESET_VAL(4'b0101)) u_c (
        .clk(clk), .rst(rst_c), .d(d_c), .q(q_c));

    // Drive one DUT for exactly one edge and queue its expected q after that edge.
    task automatic step(input logic [1:0] id, input logic r, input logic [7:0] dv,
                        input logic [7:0] e);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        case (id)
            2'd0:    begin rst_a = r; d_a = dv[3:0]; end
            2'd1:    begin rst_b = r; d_b = dv;      end
            default: begin rst_c = r; d_c = dv[3:0]; end
        endcase
        sb_q.push_back('{id: id, exp: e});
    endtask

    // Monitor: after each edge, pop one expectation (if any) and compare.
    initial begin
        exp_t       it;
        logic [7:0] act;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.id)
                    2'd0:    act = {4'd0, q_a};
                    2'd1:    act = q_b;
                    default: act = {4'd0, q_c};
                endcase
                n_vec++;
                if (act !== it.exp) begin
                    n_miss++;
                    $display("FAIL vec%0d dut%0d: q=%h expected=%h", n_vec, it.id, act, it.exp);
                end
            end
        end
    end

    initial begin
        int waited;
        // DUT A: reset with data present (reset wins), then load.
        step(2'd0, 1'b1, 8'h0A, 8'h00);
        step(2'd0, 1'b0, 8'h0C, 8'h0C);
        // d glitches between edges; only the settled value is captured.
        @(negedge clk);
        d_a = 4'b1100;
        sb_q.push_back('{id: 2'd0, exp: 8'h03});
        #1 d_a = 4'b1101;
        #1 d_a = 4'b0100;
        #1 d_a = 4'b0011;
        // Back-to-back words.
        step(2'd0, 1'b0, 8'h0F, 8'h0F);
        step(2'd0, 1'b0, 8'h0E, 8'h0E);
        step(2'd0, 1'b0, 8'h01, 8'h01);
        step(2'd0, 1'b1, 8'h0A, 8'h00);
        step(2'd0, 1'b0, 8'h0A, 8'h0A);

        // DUT B: 8-bit, 3 stages; reset mid-stream flushes in-flight words.
        step(2'd1, 1'b1, 8'hAA, 8'h00);
        step(2'd1, 1'b0, 8'h11, 8'h00);
        step(2'd1, 1'b0, 8'h22, 8'h00);
        step(2'd1, 1'b0, 8'h33, 8'h11);
        step(2'd1, 1'b0, 8'h44, 8'h22);
        step(2'd1, 1'b1, 8'h55, 8'h00);
        step(2'd1, 1'b0, 8'h66, 8'h00);
        step(2'd1, 1'b0, 8'h77, 8'h00);
        step(2'd1, 1'b0, 8'h88, 8'h66);
        step(2'd1, 1'b0, 8'h99, 8'h77);

        // DUT C: non-zero reset value.
        step(2'd2, 1'b1, 8'h0F, 8'h05);
        step(2'd2, 1'b0, 8'h09, 8'h09);
        step(2'd2, 1'b1, 8'h03, 8'h05);

        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #3;
        if (sb_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d pending expected=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
